// File: rtl/regfile_wb_queue_if.sv
// Write-back queue bus: memory/ALU write sources, register-file write port,
// forwarding lookup ports and queue status.
interface regfile_wb_queue_if #(
  parameter int PTR_W = 2
);
  logic             mem_valid;
  logic [4:0]       mem_addr;
  logic [31:0]      mem_data;
  logic             alu_valid;
  logic [4:0]       alu_addr;
  logic [31:0]      alu_data;
  logic             in_ready;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic [4:0]       fwd1_addr;
  logic             fwd1_hit;
  logic [31:0]      fwd1_data;
  logic [4:0]       fwd2_addr;
  logic             fwd2_hit;
  logic [31:0]      fwd2_data;
  logic [PTR_W:0]   count;
  logic             overflow;

  modport master (
    output mem_valid, mem_addr, mem_data,
    output alu_valid, alu_addr, alu_data,
    output fwd1_addr, fwd2_addr,
    input  in_ready, wb_addr, wb_data,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
    input  count, overflow
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data,
    input  alu_valid, alu_addr, alu_data,
    input  fwd1_addr, fwd2_addr,
    output in_ready, wb_addr, wb_data,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
    output count, overflow
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue: merges memory and ALU register writes, drains one
// per cycle to the register file and forwards still-pending values to decode.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_queue_if.slave bus
);

  localparam logic [PTR_W:0] RDY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic [4:0]       wb_addr_p1;
  logic [31:0]      wb_data_p1;
  logic             ovf;

  logic             mem_w;
  logic             alu_w;
  logic             enq_mem;
  logic             enq_alu;
  logic [1:0]       enq_n;
  logic             deq;
  logic [PTR_W-1:0] alu_slot;
  logic [32:0]      fwd1_res;
  logic [32:0]      fwd2_res;

  // r0 writes are architectural no-ops, so they are neither queued nor counted as offers
  assign mem_w    = bus.mem_valid && (bus.mem_addr != 5'd0);
  assign alu_w    = bus.alu_valid && (bus.alu_addr != 5'd0);
  assign bus.in_ready = (cnt <= RDY_MAX);
  assign enq_mem  = bus.in_ready && mem_w;
  assign enq_alu  = bus.in_ready && alu_w;
  assign enq_n    = {1'b0, enq_mem} + {1'b0, enq_alu};
  assign deq      = (cnt != '0);
  assign alu_slot = tail + PTR_W'(enq_mem);

  // Stage p0 -> p1: queue control, drain to the write-back register
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      q_vld      <= '0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
      ovf        <= 1'b0;
    end else begin
      if (deq) begin
        wb_addr_p1    <= q_addr[head];
        wb_data_p1    <= q_data[head];
        q_vld[head]   <= 1'b0;
        head          <= head + 1'b1;
      end else begin
        wb_addr_p1 <= '0;
        wb_data_p1 <= '0;
      end
      if (enq_mem) q_vld[tail]     <= 1'b1;
      if (enq_alu) q_vld[alu_slot] <= 1'b1;
      tail <= tail + PTR_W'(enq_n);
      cnt  <= cnt + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq);
      if (!bus.in_ready && (mem_w || alu_w)) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_mem) begin
      q_addr[tail] <= bus.mem_addr;
      q_data[tail] <= bus.mem_data;
    end
    if (enq_alu) begin
      q_addr[alu_slot] <= bus.alu_addr;
      q_data[alu_slot] <= bus.alu_data;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest
  function automatic logic [32:0] fwd_lookup(input logic [4:0] a);
    logic [32:0]      res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = '0;
    if (a != 5'd0) begin
      if (wb_addr_p1 == a) res = {1'b1, wb_data_p1};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (q_vld[idx] && (q_addr[idx] == a)) res = {1'b1, q_data[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd1_res = fwd_lookup(bus.fwd1_addr);
    fwd2_res = fwd_lookup(bus.fwd2_addr);
  end

  assign bus.fwd1_hit  = fwd1_res[32];
  assign bus.fwd1_data = fwd1_res[31:0];
  assign bus.fwd2_hit  = fwd2_res[32];
  assign bus.fwd2_data = fwd2_res[31:0];
  assign bus.wb_addr   = wb_addr_p1;
  assign bus.wb_data   = wb_data_p1;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized bench for regfile_wb_queue against a queue-based reference model,
// with directed scenarios for latency, ordering, overflow, reset and forwarding.
module tb_regfile_wb_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_queue_if #(.PTR_W(2)) bus ();

  regfile_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_wba;
  logic [31:0] m_wbd;
  logic        m_ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] m_fwd(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == a) return {1'b1, mq[i].data};
    if (m_wba == a) return {1'b1, m_wbd};
    return 33'd0;
  endfunction

  // Drive one cycle of stimulus, compare everything against the model, then
  // advance the model across the posedge.
  task automatic cycle(input logic r, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md, input logic av, input logic [4:0] aa,
                       input logic [31:0] ad, input logic [4:0] f1a, input logic [4:0] f2a);
    logic [32:0] f1;
    logic [32:0] f2;
    logic        ready;
    ent_t        e;
    @(negedge clk);
    rst           = r;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.fwd1_addr = f1a; bus.fwd2_addr = f2a;
    #1;
    f1 = m_fwd(f1a);
    f2 = m_fwd(f2a);
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() <= 2));
    chk("count",     32'(bus.count),     32'(mq.size()));
    chk("wb_addr",   32'(bus.wb_addr),   32'(m_wba));
    chk("wb_data",   bus.wb_data,        m_wbd);
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("fwd1_hit",  32'(bus.fwd1_hit),  32'(f1[32]));
    chk("fwd1_data", bus.fwd1_data,      f1[31:0]);
    chk("fwd2_hit",  32'(bus.fwd2_hit),  32'(f2[32]));
    chk("fwd2_data", bus.fwd2_data,      f2[31:0]);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_wba = 5'd0; m_wbd = 32'd0; m_ovf = 1'b0;
    end else begin
      ready = (mq.size() <= 2);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wba = e.addr; m_wbd = e.data;
      end else begin
        m_wba = 5'd0; m_wbd = 32'd0;
      end
      if (ready) begin
        if (mv && ma != 5'd0) mq.push_back('{addr: ma, data: md});
        if (av && aa != 5'd0) mq.push_back('{addr: aa, data: ad});
      end else if ((mv && ma != 5'd0) || (av && aa != 5'd0)) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] f1a, input logic [4:0] f2a);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f1a, f2a);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.fwd1_addr = '0;   bus.fwd2_addr = '0;
    repeat (2) @(posedge clk);
    m_wba = 5'd0; m_wbd = 32'd0; m_ovf = 1'b0;

    // Reset then idle
    idle(5'd5, 5'd0);
    #1;
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wb_addr",  32'(bus.wb_addr),  32'd0);

    // Single ALU write, two-edge latency
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0);
    #1; chk("single_count", 32'(bus.count), 32'd1);
    idle(5'd5, 5'd0);
    #1; chk("single_wba", 32'(bus.wb_addr), 32'd5);
    chk("single_wbd", bus.wb_data, 32'h12345678);
    chk("single_cnt0", 32'(bus.count), 32'd0);
    idle(5'd5, 5'd0);
    #1; chk("single_wb0", 32'(bus.wb_addr), 32'd0);

    // Dual write to the same register; r0 write alongside is dropped
    cycle(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
    #1; chk("dup_fwd_young", bus.fwd1_data, 32'hB);
    cycle(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    #1; chk("dup_first", bus.wb_data, 32'hA);
    idle(5'd3, 5'd0);
    #1; chk("dup_second", bus.wb_data, 32'hB);
    repeat (2) idle(5'd0, 5'd3);
    #1; chk("r0_never", 32'(bus.wb_addr), 32'd0);

    // Fill with dual writes across several refills to exercise wrap and overflow
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++)
        cycle(1'b0, 1'b1, 5'(8 + j), $urandom, 1'b1, 5'(16 + j), $urandom,
              5'(8 + j), 5'(16 + j));
      if (k == 0) begin
        #1; chk("ovf_set", 32'(bus.overflow), 32'd1);
      end
      repeat (3) idle(5'(8 + k), 5'(17 + k));
    end

    // Reset while entries are pending
    cycle(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd7, 5'd6);
    cycle(1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 5'd7, 5'd6);
    cycle(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, 5'd7, 5'd6);
    #1;
    chk("rst2_count", 32'(bus.count),    32'd0);
    chk("rst2_wba",   32'(bus.wb_addr),  32'd0);
    chk("rst2_ovf",   32'(bus.overflow), 32'd0);
    repeat (3) idle(5'd1, 5'd2);

    // Queue entry outranks the wb_* register for the same address
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd9);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h2, 5'd0, 5'd9);
    #1;
    chk("prio_wb",   bus.wb_data,         32'h1);
    chk("prio_hit",  32'(bus.fwd2_hit),   32'd1);
    chk("prio_data", bus.fwd2_data,       32'h2);
    idle(5'd0, 5'd9);
    #1;
    chk("prio_wb_hit",  32'(bus.fwd2_hit), 32'd1);
    chk("prio_wb_data", bus.fwd2_data,     32'h2);
    idle(5'd0, 5'd9);

    // Random traffic with small address space for collisions and r0 writes
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    repeat (5) idle(5'd1, 5'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
